// File: rtl/m602_pkg.sv
// Shared pdp8 pulse/delay definitions: FSM state encodings reused by the
// pulse amplifier and the later delay and one-shot modules.
package m602_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_REC   = 2'd2
  } pst_e;

  localparam int NUM_CH = 2;

endpackage

// File: rtl/m602_channel.sv
// One pulse-amplifier channel: a rising trigger edge, gated by the
// conditioning level, becomes a PW-cycle pulse followed by a REC-cycle lockout.
module m602_channel
  import m602_pkg::*;
#(
  parameter int PW  = 3,
  parameter int REC = 2,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic en,
  output logic pout,
  output logic poutn
);

  localparam bit HAS_REC = (REC > 0);
  localparam int PWM1    = PW - 1;
  localparam int RECM1   = HAS_REC ? REC - 1 : 0;

  pst_e          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trig_q;
  logic          pulse_q, pulse_d;
  logic          edg;

  assign edg = trig & ~trig_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Conditioning level only matters in the edge cycle.
        if (edg && en) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(PWM1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          if (HAS_REC) begin
            state_d = ST_REC;
            cnt_d   = CW'(RECM1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_REC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    pulse_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge clk) begin
    // trig_q follows the input even in reset so a level held high through
    // reset is not mistaken for an edge afterwards.
    trig_q <= trig;
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pout  = pulse_q;
  assign poutn = ~pulse_q;

endmodule

// File: rtl/m602.sv
// Two-channel pulse amplifier: two independent m602_channel instances,
// ch0 on D1/E1 -> F1/H1 and ch1 on K1/L1 -> M1/N1.
module m602
  import m602_pkg::*;
#(
  parameter int PW  = 3,
  parameter int REC = 2,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic D1,
  input  logic E1,
  output logic F1,
  output logic H1,
  input  logic K1,
  input  logic L1,
  output logic M1,
  output logic N1
);

  logic [NUM_CH-1:0] trig, en, p, pn;

  assign trig = {K1, D1};
  assign en   = {L1, E1};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    m602_channel #(.PW(PW), .REC(REC), .CW(CW)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .trig (trig[i]),
      .en   (en[i]),
      .pout (p[i]),
      .poutn(pn[i])
    );
  end

  assign F1 = p[0];
  assign H1 = pn[0];
  assign M1 = p[1];
  assign N1 = pn[1];

endmodule

// File: tb/tb_m602.sv
// Directed bench for m602 (PW=3, REC=2): the driver applies one vector per
// cycle and queues that cycle's hand-derived outputs; a monitor checks them.
module tb_m602;

  logic clk = 1'b0;
  logic rst, D1, E1, K1, L1;
  logic F1, H1, M1, N1;

  always #5 clk = ~clk;

  m602 #(.PW(3), .REC(2), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .D1(D1), .E1(E1), .F1(F1), .H1(H1),
    .K1(K1), .L1(L1), .M1(M1), .N1(N1)
  );

  typedef struct {
    int   step;
    logic f;
    logic m;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;
  bit   done    = 1'b0;

  // One cycle: drive inputs just after the rising edge and queue the outputs
  // expected to be visible during this same cycle.
  task automatic step(input logic r, d, e, k, l, ef, em);
    rst = r; D1 = d; E1 = e; K1 = k; L1 = l;
    q.push_back('{step_no, ef, em});
    step_no++;
    @(posedge clk); #1;
  endtask

  task automatic rep(input int n, input logic r, d, e, k, l, ef, em);
    for (int i = 0; i < n; i++) step(r, d, e, k, l, ef, em);
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_tests++;
      if (F1 !== x.f || H1 !== ~x.f || M1 !== x.m || N1 !== ~x.m) begin
        n_fail++;
        $display("FAIL step%0d outputs: got F1=%b H1=%b M1=%b N1=%b, want F1=%b H1=%b M1=%b N1=%b",
                 x.step, F1, H1, M1, N1, x.f, ~x.f, x.m, ~x.m);
      end
    end
  end

  initial begin
    rst = 1'b1; D1 = 1'b1; E1 = 1'b1; K1 = 1'b1; L1 = 1'b1;
    @(posedge clk); #1;

    // Reset with both triggers held high; no pulse after release.
    rep(3, 1, 1, 1, 1, 1, 0, 0);
    rep(4, 0, 1, 1, 1, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);

    // Basic pulse: edge in N, F1 high N+1..N+3, recovery N+4..N+5.
    step(0, 1, 1, 0, 1, 0, 0);
    rep(3, 0, 1, 1, 0, 1, 1, 0);
    rep(2, 0, 1, 1, 0, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);

    // Gating: edge with E1=0, then E1 rising with D1 already high.
    step(0, 1, 0, 0, 1, 0, 0);
    rep(2, 0, 1, 0, 0, 1, 0, 0);
    rep(3, 0, 1, 1, 0, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);

    // Lockout: edges in PULSE (N+2) and last REC cycle (N+5) are discarded.
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0);
    rep(2, 0, 1, 1, 0, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);

    // Edge on the first IDLE cycle after recovery fires again.
    step(0, 1, 1, 0, 1, 0, 0);
    rep(3, 0, 0, 1, 0, 1, 1, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0);
    rep(3, 0, 1, 1, 0, 1, 1, 0);
    rep(2, 0, 1, 1, 0, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);

    // Reset mid-pulse: pulse cut the cycle after rst, and does not resume.
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 1, 0, 0);
    rep(4, 0, 1, 1, 0, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);

    // Simultaneous edges on both channels.
    step(0, 1, 1, 1, 1, 0, 0);
    rep(3, 0, 1, 1, 1, 1, 1, 1);
    rep(2, 0, 1, 1, 1, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 1, 0, 0);

    // ch1 edge during ch0 recovery; E1 drops mid-pulse without truncation.
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    rep(3, 0, 1, 0, 1, 1, 0, 1);
    rep(2, 0, 0, 0, 1, 1, 0, 0);
    rep(2, 0, 0, 0, 0, 1, 0, 0);

    done = 1'b1;
  end

  initial begin
    int budget;
    wait (done);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(negedge clk); #1;
      budget++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
